// File: rtl/mem_store_buffer.sv
// In-order store FIFO between the MEM stage and the AXI write adapter; one store in flight at a time.
// Define MEM_STORE_BUFFER_FWD_EN to forward data from the youngest matching store to loads.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  output logic        empty,
  output logic        we,
  output logic [31:0] address,
  output logic [31:0] data,
  input  logic        mem_write_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

  logic [31:0]      r_entAddr [DEPTH];
  logic [31:0]      r_entData [DEPTH];
  logic [DEPTH-1:0] r_entValid;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [1:0]       r_state;
  logic [31:0]      r_address;
  logic [31:0]      r_data;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rptrNext;
  logic [PTR_W:0]   w_countNext;
  logic             w_bypassHead;
  logic [31:0]      w_nextHeadAddr;
  logic [31:0]      w_nextHeadData;
  logic             w_conflict;

  assign st_ready    = (r_count != FULL_COUNT);
  assign w_push      = st_valid && st_ready;
  assign w_pop       = (r_state == S_WAIT) && mem_write_valid;
  assign w_rptrNext  = r_rptr + 1'b1;
  assign w_countNext = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  // When the retiring entry is the only one, the next head is the store being written this same edge.
  assign w_bypassHead   = w_push && (r_count == ONE_COUNT);
  assign w_nextHeadAddr = w_bypassHead ? st_addr : r_entAddr[w_rptrNext];
  assign w_nextHeadData = w_bypassHead ? st_data : r_entData[w_rptrNext];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_entValid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entAddr[i] <= '0;
        r_entData[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_entAddr[r_wptr]  <= st_addr;
        r_entData[r_wptr]  <= st_data;
        r_entValid[r_wptr] <= 1'b1;
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_entValid[r_rptr] <= 1'b0;
        r_rptr             <= w_rptrNext;
      end
      r_count <= w_countNext;
    end
  end

  // Head address/data are captured on entry to ISSUE and held through WAIT until retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_address <= '0;
      r_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state   <= S_ISSUE;
            r_address <= r_entAddr[r_rptr];
            r_data    <= r_entData[r_rptr];
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_pop) begin
            if (w_countNext != '0) begin
              r_state   <= S_ISSUE;
              r_address <= w_nextHeadAddr;
              r_data    <= w_nextHeadData;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign we      = (r_state == S_ISSUE);
  assign address = r_address;
  assign data    = r_data;
  assign empty   = (r_count == '0) && (r_state == S_IDLE);

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_entValid[i] && (r_entAddr[i] == ld_addr)) w_conflict = 1'b1;
    end
  end

  assign ld_conflict = w_conflict;

`ifdef MEM_STORE_BUFFER_FWD_EN
  logic [31:0] w_fwdData;

  // Scan oldest to youngest so the most recent matching store overwrites older ones.
  always_comb begin
    w_fwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_entValid[r_rptr + PTR_W'(i)] && (r_entAddr[r_rptr + PTR_W'(i)] == ld_addr))
        w_fwdData = r_entData[r_rptr + PTR_W'(i)];
    end
  end

  assign ld_fwd_valid = w_conflict;
  assign ld_fwd_data  = w_fwdData;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: stores queue expected issues, a monitor checks each we pulse.
module tb_mem_store_buffer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        empty;
  logic        we;
  logic [31:0] address;
  logic [31:0] data;
  logic        mem_write_valid;

  logic autoAck;
  logic autoMwv;
  logic manualMwv;
  logic prevWe;

  int   tests;
  int   errors;
  exp_t sbQ[$];

  assign mem_write_valid = autoMwv | manualMwv;

  mem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .st_valid(st_valid),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_ready(st_ready),
    .ld_addr(ld_addr),
    .ld_conflict(ld_conflict),
    .ld_fwd_valid(ld_fwd_valid),
    .ld_fwd_data(ld_fwd_data),
    .empty(empty),
    .we(we),
    .address(address),
    .data(data),
    .mem_write_valid(mem_write_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Pushes the expected issue first, then offers the store for exactly one edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk); #1;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    e.a = a;
    e.d = d;
    sbQ.push_back(e);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic manualAck();
    @(posedge clk); #1;
    manualMwv = 1'b1;
    @(posedge clk); #1;
    manualMwv = 1'b0;
  endtask

  task automatic waitEmpty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!empty && n < 80) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, empty}, 32'd1);
    checkOutput({name, "_sbDrained"}, sbQ.size(), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_we"}, {31'd0, we}, 32'd0);
    checkOutput({tag, "_address"}, address, 32'd0);
    checkOutput({tag, "_data"}, data, 32'd0);
    checkOutput({tag, "_ldConflict"}, {31'd0, ld_conflict}, 32'd0);
    checkOutput({tag, "_fwdValid"}, {31'd0, ld_fwd_valid}, 32'd0);
    checkOutput({tag, "_fwdData"}, ld_fwd_data, 32'd0);
    checkOutput({tag, "_stReady"}, {31'd0, st_ready}, 32'd1);
    checkOutput({tag, "_empty"}, {31'd0, empty}, 32'd1);
  endtask

  // Monitor: every we pulse must match the oldest outstanding store and be separated from the previous one.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prevWe = 1'b0;
    end else begin
      if (we) begin
        checkOutput("weGap", {31'd0, prevWe}, 32'd0);
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedWe", {31'd0, we}, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("issueAddr", address, e.a);
          checkOutput("issueData", data, e.d);
        end
      end
      prevWe = we;
    end
  end

  // Adapter model: acknowledges the write one cycle after the issue pulse.
  always begin
    @(negedge clk);
    if (autoAck && we && !reset) begin
      @(posedge clk); #1;
      autoMwv = 1'b1;
      @(posedge clk); #1;
      autoMwv = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests     = 0;
    errors    = 0;
    reset     = 1'b1;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    ld_addr   = 32'hFFFF_FFF0;
    autoAck   = 1'b0;
    autoMwv   = 1'b0;
    manualMwv = 1'b0;
    prevWe    = 1'b0;

    // Reset values.
    @(negedge clk);
    checkResetOutputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single store: issue pulse one cycle after acceptance, held until retire.
    applyStimulus(32'h1000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("t1_weBeforeIssue", {31'd0, we}, 32'd0);
    checkOutput("t1_emptyPending", {31'd0, empty}, 32'd1 - 32'd1);
    @(negedge clk);
    checkOutput("t1_wePulse", {31'd0, we}, 32'd1);
    checkOutput("t1_address", address, 32'h1000_0010);
    checkOutput("t1_data", data, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("t1_weWait", {31'd0, we}, 32'd0);
    checkOutput("t1_addressHeld", address, 32'h1000_0010);
    checkOutput("t1_dataHeld", data, 32'hDEAD_BEEF);
    @(posedge clk);
    @(posedge clk); #1;
    manualMwv = 1'b1;
    @(posedge clk); #1;
    manualMwv = 1'b0;
    @(negedge clk);
    checkOutput("t1_emptyAfterRetire", {31'd0, empty}, 32'd1);
    checkOutput("t1_weAfterRetire", {31'd0, we}, 32'd0);
    @(negedge clk);
    checkOutput("t1_weStaysLow", {31'd0, we}, 32'd0);

    // Fill to DEPTH with no completions; a fifth store must be refused.
    applyStimulus(32'h0000_A000, 32'h0000_00A0);
    applyStimulus(32'h0000_A004, 32'h0000_00A1);
    applyStimulus(32'h0000_A008, 32'h0000_00A2);
    applyStimulus(32'h0000_A00C, 32'h0000_00A3);
    @(negedge clk);
    checkOutput("t2_fullNotReady", {31'd0, st_ready}, 32'd0);
    @(posedge clk); #1;
    st_valid = 1'b1;
    st_addr  = 32'h0000_A010;
    st_data  = 32'h0000_00A4;
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_fifthRefused", {31'd0, st_ready}, 32'd0);
    @(posedge clk); #1;
    manualMwv = 1'b1;
    @(posedge clk); #1;
    manualMwv = 1'b0;
    autoAck   = 1'b1;
    @(negedge clk);
    checkOutput("t2_readyAfterRetire", {31'd0, st_ready}, 32'd1);
    waitEmpty("t2_drain");

    // Wrap-around: six stores interleaved with automatic completions.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h0000_3000 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1));
    end
    waitEmpty("t3_drain");
    autoAck = 1'b0;

    // Load address check against pending stores to the same word.
    applyStimulus(32'h0000_2000, 32'h0000_0011);
    applyStimulus(32'h0000_2000, 32'h0000_0022);
    @(negedge clk);
    ld_addr = 32'h0000_2000;
    #1;
    checkOutput("t4_conflictHit", {31'd0, ld_conflict}, 32'd1);
`ifdef MEM_STORE_BUFFER_FWD_EN
    checkOutput("t4_fwdValid", {31'd0, ld_fwd_valid}, 32'd1);
    checkOutput("t4_fwdYoungest", ld_fwd_data, 32'h0000_0022);
`else
    checkOutput("t4_fwdValidOff", {31'd0, ld_fwd_valid}, 32'd0);
    checkOutput("t4_fwdDataOff", ld_fwd_data, 32'd0);
`endif
    ld_addr = 32'h0000_2004;
    #1;
    checkOutput("t4_conflictMiss", {31'd0, ld_conflict}, 32'd0);
    ld_addr = 32'h0000_2000;
    manualAck();
    autoAck = 1'b1;
    waitEmpty("t4_drain");
    #1;
    checkOutput("t4_conflictClearedAfterDrain", {31'd0, ld_conflict}, 32'd0);
    ld_addr = 32'hFFFF_FFF0;
    autoAck = 1'b0;

    // Simultaneous push and retire with one entry in flight.
    applyStimulus(32'h0000_5000, 32'h0000_B000);
    repeat (3) @(posedge clk);
    #1;
    begin
      exp_t e;
      e.a = 32'h0000_5004;
      e.d = 32'h0000_B001;
      sbQ.push_back(e);
    end
    st_valid  = 1'b1;
    st_addr   = 32'h0000_5004;
    st_data   = 32'h0000_B001;
    manualMwv = 1'b1;
    @(posedge clk); #1;
    st_valid  = 1'b0;
    manualMwv = 1'b0;
    @(negedge clk);
    checkOutput("t5_weNewEntry", {31'd0, we}, 32'd1);
    checkOutput("t5_addrNewEntry", address, 32'h0000_5004);
    checkOutput("t5_notEmpty", {31'd0, empty}, 32'd0);
    manualAck();
    waitEmpty("t5_drain");

    // Reset while waiting on the adapter with three entries, then a stray completion.
    applyStimulus(32'h0000_6000, 32'h0000_C000);
    applyStimulus(32'h0000_6004, 32'h0000_C001);
    applyStimulus(32'h0000_6008, 32'h0000_C002);
    @(posedge clk); #1;
    reset = 1'b1;
    sbQ.delete();
    @(negedge clk);
    checkResetOutputs("t6_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    manualMwv = 1'b1;
    @(posedge clk); #1;
    manualMwv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_noWe", {31'd0, we}, 32'd0);
      checkOutput("t6_empty", {31'd0, empty}, 32'd1);
    end
    checkOutput("t6_stReady", {31'd0, st_ready}, 32'd1);

    checkOutput("final_sbEmpty", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Store queue between the MEM pipeline stage and the AXI write-channel adapter.
- Accepts single-word stores from MEM in one cycle and holds them in an in-order FIFO.
- Issues one store at a time on the adapter's data/we/address interface, and retires it on the adapter's write-done pulse.
- Decouples the pipeline from AXI write latency; gives loads an address-match check against pending stores.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- PTR_W, 2, log2(DEPTH), width of the read/write pointers.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- st_valid  input  1  MEM presents a store this cycle
- st_addr  input  32  store word address
- st_data  input  32  store data
- st_ready  output  1  buffer can accept a store (= not full)
- ld_addr  input  32  address of the load currently in MEM
- ld_conflict  output  1  ld_addr equals the address of some valid entry, including the in-flight one
- ld_fwd_valid  output  1  forwarded data valid (feature only)
- ld_fwd_data  output  32  forwarded data (feature only)
- empty  output  1  no entries and adapter idle; used by SYNC/drain
- we  output  1  one-cycle issue pulse to the write adapter
- address  output  32  head entry address; held stable until retire
- data  output  32  head entry data; held stable until retire
- mem_write_valid  input  1  adapter write-done pulse (bvalid)

Behaviour:
- Reset (async, on assertion):
  - Pointers, count and all entry valid bits cleared.
  - State = IDLE.
  - Outputs: we=0, address=0, data=0, ld_conflict=0, ld_fwd_valid=0, ld_fwd_data=0, st_ready=1, empty=1.
- Reset mid-transfer discards every entry, including the in-flight one. A later stray mem_write_valid is ignored because state is IDLE.
- Push:
  - st_valid && st_ready at an edge writes {addr,data} at wptr. wptr wraps modulo DEPTH; count+1.
  - st_ready = (count != DEPTH). It does not look ahead to a same-cycle pop.
  - A store offered while full is not accepted. MEM must stall on !st_ready.
- Pop happens only on retire. Push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE: if count != 0, go to ISSUE.
  - ISSUE: we=1 for exactly this cycle; address/data = head. Next state is WAIT.
  - WAIT: we=0; address/data still = head. On mem_write_valid: pop head (rptr+1 wrapping, count-1); next state is ISSUE if count after pop != 0 (including a same-cycle push), else IDLE.
- address/data are registered from the head at entry to ISSUE and do not change until the retire edge.
- Latency: a store pushed into an empty IDLE buffer at edge N gives we=1 in cycle N+1.
- Back-to-back: minimum of one idle (WAIT) cycle between we pulses.
- mem_write_valid in IDLE or ISSUE is ignored.
- empty = (count == 0) && state == IDLE. It is a registered-state function.
- ld_conflict is combinational: the OR over valid entries of (entry.addr == ld_addr). Full 32-bit compare.

Optional Feature:
- Macro: MEM_STORE_BUFFER_FWD_EN.
- With the macro:
  - ld_fwd_valid = ld_conflict.
  - ld_fwd_data = data of the youngest matching entry, searching from wptr-1 backwards to rptr, so the most recent store to that address wins.
- Without the macro:
  - ld_fwd_valid tied 0 and ld_fwd_data tied 0.
  - ld_conflict alone is used by the pipeline to stall the load until the store drains.

Test Plan:
- Reset then single store addr=0x1000_0010, data=0xDEAD_BEEF at edge N -> we=1 only in cycle N+1; address/data hold those values. mem_write_valid at N+5 -> empty=1 at N+6, we stays 0.
- Push 4 stores A0..A3 without completing -> st_ready=0 after the 4th. A 5th st_valid is not accepted. One mem_write_valid -> st_ready=1 next cycle. Issue order is A0,A1,A2,A3 with 1 idle cycle between pulses.
- Wrap-around: 6 stores interleaved with completions (DEPTH=4) -> wptr/rptr wrap and retired data sequence matches push order exactly.
- Load check: pending stores 0x2000->0x11, then 0x2000->0x22, with ld_addr=0x2000 -> ld_conflict=1. With the feature: ld_fwd_data=0x22. ld_addr=0x2004 -> ld_conflict=0.
- Simultaneous push and retire at count=1 -> count stays 1, next state ISSUE, new entry issued.
- Assert reset during WAIT with 3 entries, then a stray mem_write_valid -> all outputs at reset values, empty=1, no we pulse.
